// File: rtl/mm_copy_master.sv
// Bus initiator that copies len_i words from src to dst, one read then one write per word,
// over a req/gnt/rvalid core-side data port with registered outputs.
module mm_copy_master #(
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] words_done_o,
  output logic                 data_req_o,
  output logic [31:0]          data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic [31:0]          data_rdata_i
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_e;

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, words_q, words_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      timer_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      words_q <= words_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Outputs are registered from the next-state values, so req appears the cycle after the decision.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    words_d = words_q;
    timer_d = timer_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_i;
          err_d   = 1'b0;
          words_d = '0;
          if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (len_i == '0) begin
            state_d = FIN;
          end else begin
            state_d = RD_REQ;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = src_addr_i;
          end
        end
      end
      RD_REQ: begin
        if (data_gnt_i) begin
          state_d = RD_WAIT;
          req_d   = 1'b0;
          timer_d = TW'(1);
        end
      end
      RD_WAIT: begin
        if (data_rvalid_i) begin
          wdata_d = data_rdata_i;
          state_d = WR_REQ;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = dst_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WR_REQ: begin
        if (data_gnt_i) begin
          state_d = WR_WAIT;
          req_d   = 1'b0;
          timer_d = TW'(1);
        end
      end
      WR_WAIT: begin
        if (data_rvalid_i) begin
          words_d = words_q + LEN_WIDTH'(1);
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          if (words_q + LEN_WIDTH'(1) == len_q) begin
            state_d = FIN;
          end else begin
            state_d = RD_REQ;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = src_q + 32'd4;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
             (state_d == WR_REQ) || (state_d == WR_WAIT);
    done_d = (state_d == FIN);
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = words_q;
  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = 4'b1111;
  assign data_wdata_o = wdata_q;

endmodule
